// File: rtl/spi_cmd_ctrl_pkg.sv
// spi_cmd_pkg: opcodes, FSM states and frame-length decode shared by the SPI command controller.
package spi_cmd_pkg;

    localparam int ADDR_WIDTH_DEFAULT = 17;

    typedef enum logic [2:0] {
        OP_READ_AT    = 3'b000,
        OP_READ_NEXT  = 3'b001,
        OP_WRITE_AT   = 3'b100,
        OP_WRITE_NEXT = 3'b101
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_REQ,
        S_DONE,
        S_DISCARD
    } state_e;

    // Bytes per frame including the command byte; 0 marks an invalid opcode.
    function automatic logic [2:0] frame_len(input logic [2:0] op);
        return op == OP_READ_AT    ? 3'd3 :
               op == OP_READ_NEXT  ? 3'd1 :
               op == OP_WRITE_AT   ? 3'd4 :
               op == OP_WRITE_NEXT ? 3'd2 : 3'd0;
    endfunction

endpackage

// File: rtl/spi_cmd_ctrl_if.sv
// spi_cmd_ctrl_if: SPI byte stream and single-request bus handshake seen by the command controller.
interface spi_cmd_ctrl_if
    import spi_cmd_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
);
    logic                  cs_n;
    logic                  rx_valid;
    logic [7:0]            rx_byte;
    logic [7:0]            tx_byte;
    logic                  bus_req;
    logic                  bus_we;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [7:0]            bus_wr_data;
    logic                  bus_ack;
    logic [7:0]            bus_rd_data;
    logic                  busy;
    logic                  cmd_err;

    modport master (
        input  cs_n, rx_valid, rx_byte, bus_ack, bus_rd_data,
        output tx_byte, bus_req, bus_we, bus_addr, bus_wr_data, busy, cmd_err
    );

    modport slave (
        output cs_n, rx_valid, rx_byte, bus_ack, bus_rd_data,
        input  tx_byte, bus_req, bus_we, bus_addr, bus_wr_data, busy, cmd_err
    );
endinterface

// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: decodes SPI command frames into single bus read/write requests with a persistent address.
// Define SPI_CMD_TIMEOUT_EN to abandon a request after TIMEOUT_CYCLES without bus_ack.
module spi_cmd_ctrl
    import spi_cmd_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
`ifdef SPI_CMD_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input logic            sys_clk,
    input logic            reset,
    spi_cmd_ctrl_if.master bus
);

    state_e                state_q, state_d;
    logic [2:0]            op_q, op_d;
    logic                  a16_q, a16_d;
    logic [1:0]            idx_q, idx_d;
    logic [1:0]            last_q, last_d;
    logic [7:0]            b1_q, b1_d;
    logic [7:0]            b2_q, b2_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [7:0]            wd_q, wd_d;
    logic [7:0]            tx_q, tx_d;
    logic                  err_q, err_d;
    logic [2:0]            len;
    logic [16:0]           at_addr;
    logic                  issue;

    assign len = frame_len(bus.rx_byte[7:5]);

`ifdef SPI_CMD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge sys_clk) begin
        if (reset || state_q != S_REQ) cnt_q <= '0;
        else cnt_q <= cnt_q + 1'b1;
    end
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a16_d   = a16_q;
        idx_d   = idx_q;
        last_d  = last_q;
        b1_d    = b1_q;
        b2_d    = b2_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wd_d    = wd_q;
        tx_d    = tx_q;
        err_d   = err_q;
        issue   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.rx_valid && !bus.cs_n) begin
                    op_d    = bus.rx_byte[7:5];
                    a16_d   = bus.rx_byte[0];
                    idx_d   = 2'd1;
                    last_d  = len[1:0] - 2'd1;
                    err_d   = err_q | (len == 3'd0);
                    issue   = len == 3'd1;
                    state_d = len == 3'd0 ? S_DISCARD : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (bus.cs_n) state_d = S_IDLE;
                else if (bus.rx_valid) begin
                    b1_d  = idx_q == 2'd1 ? bus.rx_byte : b1_q;
                    b2_d  = idx_q == 2'd2 ? bus.rx_byte : b2_q;
                    idx_d = idx_q + 2'd1;
                    issue = idx_q == last_q;
                end
            end
            S_REQ: begin
                err_d = err_q | bus.rx_valid;
                if (bus.bus_ack) begin
                    tx_d    = we_q ? tx_q : bus.bus_rd_data;
                    state_d = bus.cs_n ? S_IDLE : S_DONE;
                end
`ifdef SPI_CMD_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = bus.cs_n ? S_IDLE : S_DONE;
                end
`endif
            end
            S_DONE, S_DISCARD: state_d = bus.cs_n ? S_IDLE : state_q;
            default: state_d = S_IDLE;
        endcase
        // The strobe completing a frame always carries addr_lo (AT ops) or the write data (WRITE_NEXT).
        at_addr = {a16_q, op_d == OP_WRITE_AT ? b2_q : b1_q, bus.rx_byte};
        if (issue) begin
            state_d = S_REQ;
            we_d    = op_d[2];
            wd_d    = !op_d[2] ? wd_q : op_d == OP_WRITE_NEXT ? bus.rx_byte : b1_q;
            addr_d  = op_d[0] ? addr_q + ADDR_WIDTH'(1) : ADDR_WIDTH'(at_addr);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a16_q   <= 1'b0;
            idx_q   <= '0;
            last_q  <= '0;
            b1_q    <= '0;
            b2_q    <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wd_q    <= '0;
            tx_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a16_q   <= a16_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            b1_q    <= b1_d;
            b2_q    <= b2_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wd_q    <= wd_d;
            tx_q    <= tx_d;
            err_q   <= err_d;
        end
    end

    assign bus.bus_req     = state_q == S_REQ;
    assign bus.busy        = state_q == S_REQ;
    assign bus.bus_we      = we_q;
    assign bus.bus_addr    = addr_q;
    assign bus.bus_wr_data = wd_q;
    assign bus.tx_byte     = tx_q;
    assign bus.cmd_err     = err_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// tb_spi_cmd_ctrl: random SPI command frames against a queue-based reference model with a decoupled bus monitor.
module tb_spi_cmd_ctrl;
    import spi_cmd_pkg::*;

    localparam int AW = 17;

    typedef struct {
        logic        we;
        logic [16:0] addr;
        logic [7:0]  wd;
    } req_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    spi_cmd_ctrl_if #(.ADDR_WIDTH(AW)) bus_if ();

`ifdef SPI_CMD_TIMEOUT_EN
    spi_cmd_ctrl #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(8)) dut (.sys_clk(clk), .reset(reset), .bus(bus_if));
`else
    spi_cmd_ctrl #(.ADDR_WIDTH(AW)) dut (.sys_clk(clk), .reset(reset), .bus(bus_if));
`endif

    int          checks = 0;
    int          errors = 0;
    req_t        exp_q[$];
    req_t        cur;
    req_t        rq;
    logic [16:0] mdl_addr = '0;
    logic [7:0]  mdl_wd = '0;
    logic [7:0]  mdl_tx = '0;
    logic        mdl_err = 1'b0;
    logic [16:0] last_addr = '0;
    bit          ack_en = 1'b1;
    bit          rd_fix_en = 1'b0;
    logic [7:0]  rd_fix = '0;
    logic [7:0]  fb[4];
    logic [2:0]  ops[4] = '{3'b000, 3'b001, 3'b100, 3'b101};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int mlen(input logic [2:0] op);
        return op == 3'b000 ? 3 : op == 3'b001 ? 1 : op == 3'b100 ? 4 : op == 3'b101 ? 2 : 0;
    endfunction

    // Bus arbiter: acks each request after 0..3 cycles, random read data every cycle.
    initial begin
        int dly = 0;
        bus_if.bus_ack = 1'b0;
        bus_if.bus_rd_data = '0;
        forever begin
            @(posedge clk);
            #1;
            bus_if.bus_ack = 1'b0;
            bus_if.bus_rd_data = 8'($urandom);
            if (bus_if.bus_req && ack_en) begin
                if (dly == 0) begin
                    bus_if.bus_ack = 1'b1;
                    if (rd_fix_en) bus_if.bus_rd_data = rd_fix;
                    dly = $urandom_range(0, 3);
                end else dly--;
            end
        end
    end

    // Monitor: pops one expectation per request rising edge and checks the post-ack state.
    initial begin
        logic req_prev = 1'b0;
        bit   tx_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                req_prev = 1'b0;
                tx_pend = 1'b0;
            end else begin
                if (tx_pend) begin
                    chk("tx_after_ack", 32'(bus_if.tx_byte), 32'(mdl_tx));
                    chk("req_after_ack", 32'(bus_if.bus_req), 0);
                    chk("busy_after_ack", 32'(bus_if.busy), 0);
                    tx_pend = 1'b0;
                end
                if (bus_if.bus_req && !req_prev) begin
                    chk("req_expected", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        cur = exp_q.pop_front();
                        chk("bus_we", 32'(bus_if.bus_we), 32'(cur.we));
                        chk("bus_addr", 32'(bus_if.bus_addr), 32'(cur.addr));
                        chk("bus_wr_data", 32'(bus_if.bus_wr_data), 32'(cur.wd));
                        chk("busy_with_req", 32'(bus_if.busy), 1);
                        last_addr = bus_if.bus_addr;
                    end
                end
                if (bus_if.bus_req && bus_if.bus_ack) begin
                    if (!cur.we) mdl_tx = bus_if.bus_rd_data;
                    tx_pend = 1'b1;
                end
                req_prev = bus_if.bus_req;
            end
        end
    end

    task automatic send(input logic [7:0] b, input bit with_cs, input int gap);
        bus_if.rx_byte = b;
        bus_if.rx_valid = 1'b1;
        if (with_cs) bus_if.cs_n = 1'b1;
        @(posedge clk);
        #1;
        bus_if.rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    // mode 0: cs_n rises after the bus op; 1: cs_n rises right after the last byte; 2: last byte shares cs_n rising.
    task automatic frame(input int n, input int mode, input bit ovr);
        int   len, eff, t;
        req_t e;
        len = mlen(fb[0][7:5]);
        eff = mode == 2 ? n - 1 : n;
        if (eff > 0 && len == 0) mdl_err = 1'b1;
        else if (len > 0 && eff >= len) begin
            e.we = fb[0][7];
            e.addr = fb[0][5] ? mdl_addr + 17'd1 : {fb[0][0], fb[len-2], fb[len-1]};
            e.wd = fb[0][7] ? fb[1] : mdl_wd;
            mdl_addr = e.addr;
            mdl_wd = e.wd;
            exp_q.push_back(e);
            if (ovr) mdl_err = 1'b1;
        end
        if (ovr) ack_en = 1'b0;
        bus_if.cs_n = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < n; i++)
            send(fb[i], mode == 2 && i == n - 1, i == n - 1 ? 0 : int'($urandom_range(0, 2)));
        if (mode == 1) bus_if.cs_n = 1'b1;
        if (ovr) begin
            send(8'h55, 1'b0, 1);
            ack_en = 1'b1;
        end
        t = 0;
        while (bus_if.bus_req && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("req_completes", 32'(bus_if.bus_req), 0);
        bus_if.cs_n = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("cmd_err", 32'(bus_if.cmd_err), 32'(mdl_err));
        chk("tx_byte", 32'(bus_if.tx_byte), 32'(mdl_tx));
        chk("busy_idle", 32'(bus_if.busy), 0);
        chk("exp_drained", 32'(exp_q.size()), 0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req", 32'(bus_if.bus_req), 0);
        chk("rst_we", 32'(bus_if.bus_we), 0);
        chk("rst_addr", 32'(bus_if.bus_addr), 0);
        chk("rst_wd", 32'(bus_if.bus_wr_data), 0);
        chk("rst_tx", 32'(bus_if.tx_byte), 0);
        chk("rst_busy", 32'(bus_if.busy), 0);
        chk("rst_err", 32'(bus_if.cmd_err), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n, len, t;
        bus_if.cs_n = 1'b1;
        bus_if.rx_valid = 1'b0;
        bus_if.rx_byte = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs();
        reset = 1'b0;
        @(posedge clk);
        #1;

        fb = '{8'h81, 8'h5A, 8'h80, 8'h00};
        frame(4, 0, 1'b0);
        chk("plan_write_at", 32'(last_addr), 32'h18000);
        rd_fix_en = 1'b1;
        rd_fix = 8'hA5;
        fb = '{8'h00, 8'h12, 8'h34, 8'h00};
        frame(3, 0, 1'b0);
        chk("plan_read_at", 32'(last_addr), 32'h01234);
        chk("plan_read_tx", 32'(bus_if.tx_byte), 32'hA5);
        fb[0] = 8'h20;
        frame(1, 0, 1'b0);
        chk("plan_read_next", 32'(last_addr), 32'h01235);
        rd_fix_en = 1'b0;
        fb = '{8'h81, 8'h00, 8'hFF, 8'hFF};
        frame(4, 0, 1'b0);
        fb = '{8'hA0, 8'h11, 8'h00, 8'h00};
        frame(2, 0, 1'b0);
        chk("plan_wrap_addr", 32'(last_addr), 0);
        chk("plan_wrap_data", 32'(bus_if.bus_wr_data), 32'h11);
        fb = '{8'h80, 8'h77, 8'h12, 8'h34};
        frame(2, 0, 1'b0);
        fb[0] = 8'h20;
        frame(1, 0, 1'b0);
        chk("plan_trunc_next", 32'(last_addr), 1);

        for (int k = 0; k < 150; k++) begin
            fb[0] = {ops[$urandom_range(0, 3)], 5'($urandom)};
            for (int j = 1; j < 4; j++) fb[j] = 8'($urandom);
            len = mlen(fb[0][7:5]);
            n = (len > 1 && $urandom_range(0, 4) == 0) ? int'($urandom_range(1, len - 1)) : len;
            frame(n, int'($urandom_range(0, 2)), 1'b0);
        end

        fb = '{8'h40, 8'h00, 8'h20, 8'h00};
        frame(3, 0, 1'b0);
        chk("invalid_err", 32'(bus_if.cmd_err), 1);

        ack_en = 1'b0;
        rq.we = 1'b0;
        rq.addr = mdl_addr + 17'd1;
        rq.wd = mdl_wd;
        exp_q.push_back(rq);
        bus_if.cs_n = 1'b0;
        @(posedge clk);
        #1;
        send(8'h20, 1'b0, 2);
        chk("req_before_reset", 32'(bus_if.bus_req), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_outputs();
        reset = 1'b0;
        bus_if.cs_n = 1'b1;
        mdl_addr = '0;
        mdl_wd = '0;
        mdl_tx = '0;
        mdl_err = 1'b0;
        ack_en = 1'b1;
        @(posedge clk);
        #1;
        fb[0] = 8'h20;
        frame(1, 0, 1'b0);
        chk("addr_after_reset", 32'(last_addr), 1);

`ifdef SPI_CMD_TIMEOUT_EN
        ack_en = 1'b0;
        rq.we = 1'b0;
        rq.addr = mdl_addr + 17'd1;
        rq.wd = mdl_wd;
        mdl_addr = rq.addr;
        exp_q.push_back(rq);
        bus_if.cs_n = 1'b0;
        @(posedge clk);
        #1;
        send(8'h20, 1'b0, 0);
        t = 0;
        while (bus_if.bus_req && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("timeout_len", 32'(t), 8);
        mdl_err = 1'b1;
        bus_if.cs_n = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("timeout_err", 32'(bus_if.cmd_err), 1);
        chk("timeout_tx", 32'(bus_if.tx_byte), 32'(mdl_tx));
        ack_en = 1'b1;
`endif

        fb[0] = 8'h20;
        frame(1, 0, 1'b1);
        chk("overrun_err", 32'(bus_if.cmd_err), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
